// File: rtl/hazard_scoreboard.sv
// Hazard, forwarding and stall controller for the five-stage pipeline.
// Drives the operand bypass selects, the four pipeline-register controls and
// the PC enable, and tracks a single non-pipelined multi-cycle multiplier.
module hazard_scoreboard #(
  parameter int REG_W       = 5,
  parameter int MUL_LAT     = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic                   id_is_mul,
  input  logic                   id_writes,
  input  logic [REG_W-1:0]       id_rs1,
  input  logic [REG_W-1:0]       id_rs2,
  input  logic [REG_W-1:0]       id_rd,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic                   ex_valid,
  input  logic                   ex_writes,
  input  logic                   ex_is_load,
  input  logic [REG_W-1:0]       ex_rd,
  input  logic                   mem_valid,
  input  logic                   mem_writes,
  input  logic [REG_W-1:0]       mem_rd,
  input  logic                   wb_valid,
  input  logic                   wb_writes,
  input  logic [REG_W-1:0]       wb_rd,
  input  logic                   ex_branch_taken,
  output logic [2:0]             fwdA_sel,
  output logic [2:0]             fwdB_sel,
  output logic [1:0]             if_id_ctrl,
  output logic [1:0]             id_ex_ctrl,
  output logic [1:0]             ex_mem_ctrl,
  output logic [1:0]             mem_wb_ctrl,
  output logic                   pc_enable,
  output logic                   mul_start,
  output logic                   mul_busy,
  output logic                   mul_done,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);

  localparam logic [1:0] CTRL_GO    = 2'b00;
  localparam logic [1:0] CTRL_HOLD  = 2'b01;
  localparam logic [1:0] CTRL_FLUSH = 2'b10;

  localparam logic [2:0] SEL_ID  = 3'b000;
  localparam logic [2:0] SEL_EX  = 3'b001;
  localparam logic [2:0] SEL_MEM = 3'b010;
  localparam logic [2:0] SEL_WB  = 3'b011;
  localparam logic [2:0] SEL_MUL = 3'b100;

  logic [CNT_W-1:0]       r_cnt;
  logic [REG_W-1:0]       r_mul_rd;
  logic [STALL_CNT_W-1:0] r_stall_count;

  logic       w_mul_pending;
  logic [2:0] w_sel_a;
  logic [2:0] w_sel_b;
  logic       w_load_use;
  logic       w_mul_raw;
  logic       w_mul_struct;
  logic       w_mul_waw;
  logic       w_stall;
  logic       w_stall_eff;

  // Bypass source for one operand; register 0 never forwards.
  function automatic logic [2:0] fwd_of(input logic [REG_W-1:0] rs, input logic uses);
    logic nz;
    nz = uses && (rs != '0);
    if (nz && ex_valid && ex_writes && ex_rd == rs)          return SEL_EX;
    else if (nz && mem_valid && mem_writes && mem_rd == rs)  return SEL_MEM;
    else if (nz && wb_valid && wb_writes && wb_rd == rs)     return SEL_WB;
    else if (nz && mul_done && r_mul_rd == rs)               return SEL_MUL;
    else                                                     return SEL_ID;
  endfunction

  // Load-use hazard on one operand: the EX producer is a load.
  function automatic logic lu_of(input logic [REG_W-1:0] rs, input logic uses);
    return uses && (rs != '0) && ex_valid && ex_writes && ex_is_load && (ex_rd == rs);
  endfunction

  assign mul_busy      = (r_cnt != '0);
  assign mul_done      = (r_cnt == CNT_W'(1));
  // Result not yet available: anything touching mul_rd or the unit must wait.
  assign w_mul_pending = mul_busy && !mul_done;

  // Hazard detection and issue decision.
  always_comb begin
    w_sel_a      = fwd_of(id_rs1, id_uses_rs1);
    w_sel_b      = fwd_of(id_rs2, id_uses_rs2);
    w_load_use   = lu_of(id_rs1, id_uses_rs1) || lu_of(id_rs2, id_uses_rs2);
    w_mul_raw    = w_mul_pending &&
                   ((id_uses_rs1 && id_rs1 != '0 && id_rs1 == r_mul_rd) ||
                    (id_uses_rs2 && id_rs2 != '0 && id_rs2 == r_mul_rd));
    w_mul_struct = w_mul_pending && id_is_mul;
    w_mul_waw    = w_mul_pending && id_writes && id_rd != '0 && id_rd == r_mul_rd;
    w_stall      = id_valid && (w_load_use || w_mul_raw || w_mul_struct || w_mul_waw);
    w_stall_eff  = w_stall && !ex_branch_taken;
    mul_start    = rst_n && id_valid && id_is_mul && !w_stall && !ex_branch_taken;
  end

  // Pipeline controls: reset, then branch flush, then stall, else all go.
  always_comb begin
    fwdA_sel    = w_sel_a;
    fwdB_sel    = w_sel_b;
    if_id_ctrl  = CTRL_GO;
    id_ex_ctrl  = CTRL_GO;
    ex_mem_ctrl = CTRL_GO;
    mem_wb_ctrl = CTRL_GO;
    pc_enable   = 1'b1;
    if (!rst_n) begin
      fwdA_sel    = SEL_ID;
      fwdB_sel    = SEL_ID;
      if_id_ctrl  = CTRL_FLUSH;
      id_ex_ctrl  = CTRL_FLUSH;
      ex_mem_ctrl = CTRL_FLUSH;
      mem_wb_ctrl = CTRL_FLUSH;
      pc_enable   = 1'b0;
    end else if (ex_branch_taken) begin
      if_id_ctrl  = CTRL_FLUSH;
      id_ex_ctrl  = CTRL_FLUSH;
    end else if (w_stall) begin
      if_id_ctrl  = CTRL_HOLD;
      id_ex_ctrl  = CTRL_FLUSH;
      pc_enable   = 1'b0;
    end
  end

  // Multiplier occupancy counter and saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_mul_rd      <= '0;
      r_stall_count <= '0;
    end else begin
      if (mul_start) begin
        r_cnt    <= CNT_W'(MUL_LAT);
        r_mul_rd <= id_rd;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_stall_eff && r_stall_count != '1)
        r_stall_count <= r_stall_count + STALL_CNT_W'(1);
    end
  end

  assign stall_count = r_stall_count;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard, forwarding and stall controller for the five-stage pipeline, with a scoreboard for a single non-pipelined multi-cycle multiplier. It sits beside the ID stage and drives the operand-bypass muxes, the four pipeline-register controls and the PC enable. It also keeps a saturating stall-cycle counter for performance measurement. Unlike the single-cycle detector it replaces, it does the following:
- forwards rs1 and rs2 independently;
- forwards from WB;
- handles branch flush and multiplier busy, data and WAW hazards.

## Interface
Parameters:
- REG_W, 5, register-address width; register 0 is hard-wired zero and is never forwarded or scoreboarded
- MUL_LAT, 4, multiplier latency in cycles from issue to result (≥2)
- STALL_CNT_W, 16, width of stall_count

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- id_valid, id_is_mul, id_writes  in  1 each  ID instruction valid / multiply / writes a register
- id_rs1, id_rs2, id_rd  in  REG_W each  ID source and destination registers
- id_uses_rs1, id_uses_rs2  in  1 each  the operand is actually read
- ex_valid, ex_writes, ex_is_load  in  1 each  EX stage status
- ex_rd  in  REG_W  EX destination
- mem_valid, mem_writes  in  1 each; mem_rd  in  REG_W
- wb_valid, wb_writes  in  1 each; wb_rd  in  REG_W
- ex_branch_taken  in  1  resolved taken branch or jump in EX
- fwdA_sel, fwdB_sel  out  3 each  bypass select: 000 ID, 001 EX, 010 MEM, 011 WB, 100 MUL
- if_id_ctrl, id_ex_ctrl, ex_mem_ctrl, mem_wb_ctrl  out  2 each  00 GO, 01 HOLD, 10 FLUSH
- pc_enable  out  1
- mul_start  out  1  multiply issues into the multiplier this cycle
- mul_busy  out  1  multiplier occupied (counter ≠ 0)
- mul_done  out  1  multiplier result valid this cycle
- stall_count  out  STALL_CNT_W  cycles with a hazard stall, saturating

## Operation
Per-operand forwarding, evaluated separately for rs1 (needs id_uses_rs1) and rs2:
- A source matches when rs ≠ 0, the stage is valid and writes, and its rd equals rs.
- Priority is EX > MEM > WB > MUL (mul_done and mul_rd == rs) > ID.
- If EX matches and ex_is_load, the result is a load-use stall and the select is don't-care.

Multiplier scoreboard state: a counter cnt (0..MUL_LAT) and a register mul_rd.
- mul_busy = (cnt ≠ 0).
- mul_done = (cnt == 1).

Stall conditions, active only when id_valid:
- (a) load-use, as above;
- (b) a used rs equals mul_rd while mul_busy and not mul_done;
- (c) id_is_mul while mul_busy and not mul_done (structural);
- (d) id_writes, id_rd ≠ 0, id_rd == mul_rd, mul_busy and not mul_done (WAW).

Control outputs, highest priority first:
- Reset (rst_n low): all four ctrls FLUSH, pc_enable 0, mul_start 0, fwd sels 000.
- ex_branch_taken: if_id FLUSH, id_ex FLUSH, ex_mem GO, mem_wb GO, pc_enable 1. Any stall is discarded and no multiply issues.
- Stall: if_id HOLD, id_ex FLUSH, ex_mem GO, mem_wb GO, pc_enable 0.
- Otherwise all GO, pc_enable 1.

mul_start = id_valid & id_is_mul & no stall & no branch flush & rst_n.

Sequential update on the rising edge:
- !rst_n: cnt←0, mul_rd←0, stall_count←0. Reset mid-multiply abandons the multiply.
- mul_start: cnt←MUL_LAT, mul_rd←id_rd. Back-to-back issue in the mul_done cycle is legal; the reload wins over the decrement.
- Otherwise, if cnt ≠ 0: cnt←cnt−1.
- Stall asserted and not branch flush: stall_count←stall_count+1, holding at all-ones.

## Timing
- fwd sels, ctrls, pc_enable, mul_start, mul_busy and mul_done are combinational from the inputs and registered state, all within the same cycle.
- A multiply issued in cycle t gives mul_busy high in cycles t+1..t+MUL_LAT and mul_done high in cycle t+MUL_LAT.
  - Dependants stall in t+1..t+MUL_LAT−1 and forward from MUL in t+MUL_LAT.
- A load-use stall lasts exactly one cycle. The next cycle the load is in MEM, and forwarding comes from MEM, not a data path from WB.
- Reset values: cnt 0, mul_busy 0, mul_done 0, stall_count 0. While rst_n is low, the outputs are as in the reset case above.
- stall_count updates one cycle after the stall cycle it counts.

## Test plan
- ALU forwarding: EX rd=3 and MEM rd=3 valid, ID rs1=3, rs2=3 → fwdA=fwdB=001. EX rd=0 with rs1=0 → fwdA=000.
- Independent operands: MEM rd=4, WB rd=5, ID rs1=4, rs2=5 → fwdA=010, fwdB=011, no stall.
- Load-use: ex_is_load, ex_rd=7, ID rs2=7 → one cycle of if_id HOLD, id_ex FLUSH, pc_enable 0. The next cycle, with MEM rd=7, gives fwdB=010 and stall_count=1.
- Multiply (MUL_LAT=4): mul issues rd=9 at t, dependant reads 9 → stalls t+1..t+3, mul_done and fwd=100 at t+4. A second mul in ID at t+4 issues, and cnt reloads to 4.
- WAW/structural: mul busy on rd=9 (cnt 3), ID ALU writes 9 → stall. With ID mul instead → stall until mul_done.
- Branch and reset: ex_branch_taken together with a pending stall → if_id and id_ex FLUSH, pc_enable 1, mul_start 0, stall_count unchanged. rst_n low at cnt=2 → cnt 0 and mul_busy 0 next cycle.
